// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer memory arbiter.
package fb_arb_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [1:0] {
        REQ_SCAN = 2'd0,
        REQ_RAS  = 2'd1,
        REQ_CPU  = 2'd2
    } req_id_t;

    // Next requester in round-robin order scan -> ras -> cpu -> scan.
    function automatic req_id_t rr_next(input req_id_t id);
        req_id_t nxt;
        case (id)
            REQ_SCAN: nxt = REQ_RAS;
            REQ_RAS:  nxt = REQ_CPU;
            REQ_CPU:  nxt = REQ_SCAN;
            default:  nxt = REQ_SCAN;
        endcase
        return nxt;
    endfunction

    // Select one requester's bit out of a per-requester vector.
    function automatic logic req_bit(input logic [N_REQ-1:0] vec, input req_id_t id);
        logic b;
        case (id)
            REQ_SCAN: b = vec[0];
            REQ_RAS:  b = vec[1];
            REQ_CPU:  b = vec[2];
            default:  b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fb_arb_tag_fifo.sv
// Register FIFO of requester ids for outstanding memory reads.
// Responses come back in issue order, so the head names the next reader.
module fb_arb_tag_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  req_id_t                push_id_i,
    input  logic                   pop_i,
    output req_id_t                head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign count_o   = cnt_q;
    assign head_o    = mem_q[rd_ptr_q];
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else if (!do_push_s && do_pop_s) begin
            cnt_d = cnt_q - CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag storage; cleared so a reset never leaves stale ids visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_SCAN;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Three-way Avalon-MM arbiter for the framebuffer memory port.
// Round-robin between scan-out, rasterizer and CPU, with an urgent override
// for scan-out. A stalled grant is locked until the memory accepts it.
// Read responses are routed back through a tag FIFO, one cycle late.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  logic                clk,
    input  logic                reset,
    // scan-out prefetch (read only)
    input  logic [ADDR_W-1:0]   scan_address,
    input  logic                scan_read,
    input  logic                scan_urgent,
    output logic                scan_waitrequest,
    output logic [DATA_W-1:0]   scan_readdata,
    output logic                scan_readdatavalid,
    // rasterizer pixel writer (write only)
    input  logic [ADDR_W-1:0]   ras_address,
    input  logic                ras_write,
    input  logic [DATA_W-1:0]   ras_writedata,
    input  logic [DATA_W/8-1:0] ras_byteenable,
    output logic                ras_waitrequest,
    // CPU data master
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_writedata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic                cpu_waitrequest,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_readdatavalid,
    // framebuffer memory
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_orphan
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_PEND) + 1;
    localparam logic [CNT_W-1:0] PEND_LIMIT = CNT_W'(MAX_PEND);

    // arbitration state
    req_id_t           rr_ptr_q,  rr_ptr_d;
    logic              lock_q,    lock_d;
    req_id_t           lock_id_q, lock_id_d;

    // response state
    logic              scan_rdv_q,   scan_rdv_d;
    logic              cpu_rdv_q,    cpu_rdv_d;
    logic [DATA_W-1:0] scan_rdata_q, scan_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic              err_orphan_q, err_orphan_d;

    // combinational
    logic [N_REQ-1:0]  elig_s;
    logic              pend_ok_s;
    req_id_t           cand1_s, cand2_s;
    logic              grant_vld_s;
    req_id_t           grant_id_s;
    logic              presented_s;
    logic              accept_s;
    logic              acc_is_read_s;

    // tag FIFO
    logic [CNT_W-1:0]  pend_cnt_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    req_id_t           fifo_head_s;

    // Reads need a free tag slot; writes never wait on outstanding reads.
    assign pend_ok_s = (pend_cnt_s < PEND_LIMIT);
    assign elig_s    = {(cpu_write || (cpu_read && pend_ok_s)),
                        ras_write,
                        (scan_read && pend_ok_s)};
    assign cand1_s   = rr_next(rr_ptr_q);
    assign cand2_s   = rr_next(cand1_s);

    // Grant selection: lock first, then urgent scan-out, then round-robin.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = REQ_SCAN;
        if (reset) begin
            grant_vld_s = 1'b0;
            grant_id_s  = REQ_SCAN;
        end else if (lock_q) begin
            grant_vld_s = 1'b1;
            grant_id_s  = lock_id_q;
        end else if (elig_s[0] && scan_urgent) begin
            grant_vld_s = 1'b1;
            grant_id_s  = REQ_SCAN;
        end else if (req_bit(elig_s, rr_ptr_q)) begin
            grant_vld_s = 1'b1;
            grant_id_s  = rr_ptr_q;
        end else if (req_bit(elig_s, cand1_s)) begin
            grant_vld_s = 1'b1;
            grant_id_s  = cand1_s;
        end else if (req_bit(elig_s, cand2_s)) begin
            grant_vld_s = 1'b1;
            grant_id_s  = cand2_s;
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = REQ_SCAN;
        end
    end

    // Command mux to memory; a CPU read+write collision is issued as a write.
    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_address     = {ADDR_W{1'b0}};
        m_writedata   = {DATA_W{1'b0}};
        m_byteenable  = {BE_W{1'b0}};
        acc_is_read_s = 1'b0;
        if (grant_vld_s) begin
            case (grant_id_s)
                REQ_SCAN: begin
                    m_read        = scan_read;
                    m_address     = scan_address;
                    m_byteenable  = {BE_W{1'b1}};
                    acc_is_read_s = 1'b1;
                end
                REQ_RAS: begin
                    m_write      = ras_write;
                    m_address    = ras_address;
                    m_writedata  = ras_writedata;
                    m_byteenable = ras_byteenable;
                end
                REQ_CPU: begin
                    m_write       = cpu_write;
                    m_read        = cpu_read && !cpu_write;
                    m_address     = cpu_address;
                    m_writedata   = cpu_writedata;
                    m_byteenable  = cpu_byteenable;
                    acc_is_read_s = cpu_read && !cpu_write;
                end
                default: begin
                    m_read  = 1'b0;
                    m_write = 1'b0;
                end
            endcase
        end else begin
            m_read  = 1'b0;
            m_write = 1'b0;
        end
    end

    assign presented_s = m_read || m_write;
    assign accept_s    = presented_s && !m_waitrequest;

    assign scan_waitrequest = !(accept_s && (grant_id_s == REQ_SCAN));
    assign ras_waitrequest  = !(accept_s && (grant_id_s == REQ_RAS));
    assign cpu_waitrequest  = !(accept_s && (grant_id_s == REQ_CPU));

    // Lock and round-robin pointer next-state.
    always_comb begin
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (presented_s && m_waitrequest) begin
            lock_d    = 1'b1;
            lock_id_d = grant_id_s;
        end else begin
            lock_d    = 1'b0;
            lock_id_d = lock_id_q;
        end
        if (accept_s) begin
            rr_ptr_d = rr_next(grant_id_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Arbitration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= REQ_SCAN;
            lock_q    <= 1'b0;
            lock_id_q <= REQ_SCAN;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign fifo_push_s = accept_s && acc_is_read_s && !fifo_full_s;
    assign fifo_pop_s  = m_readdatavalid && !fifo_empty_s;

    fb_arb_tag_fifo #(
        .DEPTH     (MAX_PEND)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fifo_push_s),
        .push_id_i (grant_id_s),
        .pop_i     (fifo_pop_s),
        .head_o    (fifo_head_s),
        .count_o   (pend_cnt_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Response demux next-state; responses with no tag are dropped and flagged.
    always_comb begin
        scan_rdv_d   = 1'b0;
        cpu_rdv_d    = 1'b0;
        scan_rdata_d = scan_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        err_orphan_d = err_orphan_q;
        if (fifo_pop_s) begin
            scan_rdv_d = (fifo_head_s == REQ_SCAN);
            cpu_rdv_d  = (fifo_head_s == REQ_CPU);
        end else begin
            scan_rdv_d = 1'b0;
            cpu_rdv_d  = 1'b0;
        end
        if (scan_rdv_d) begin
            scan_rdata_d = m_readdata;
        end else begin
            scan_rdata_d = scan_rdata_q;
        end
        if (cpu_rdv_d) begin
            cpu_rdata_d = m_readdata;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (m_readdatavalid && fifo_empty_s) begin
            err_orphan_d = 1'b1;
        end else begin
            err_orphan_d = err_orphan_q;
        end
    end

    // Response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_rdv_q   <= 1'b0;
            cpu_rdv_q    <= 1'b0;
            scan_rdata_q <= {DATA_W{1'b0}};
            cpu_rdata_q  <= {DATA_W{1'b0}};
            err_orphan_q <= 1'b0;
        end else begin
            scan_rdv_q   <= scan_rdv_d;
            cpu_rdv_q    <= cpu_rdv_d;
            scan_rdata_q <= scan_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign scan_readdatavalid = scan_rdv_q;
    assign scan_readdata      = scan_rdata_q;
    assign cpu_readdatavalid  = cpu_rdv_q;
    assign cpu_readdata       = cpu_rdata_q;
    assign err_orphan         = err_orphan_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: expected acceptances and read
// responses are queued as stimulus is driven and popped by two monitors.
module tb_fb_mem_arbiter;
    import fb_arb_pkg::*;

    localparam logic [31:0] SCAN_A = 32'h1000_0000;
    localparam logic [31:0] RAS_A  = 32'h2000_0000;
    localparam logic [31:0] CPU_A  = 32'h3000_0000;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] scan_address;
    logic        scan_read, scan_urgent, scan_waitrequest, scan_readdatavalid;
    logic [31:0] scan_readdata;
    logic [31:0] ras_address, ras_writedata;
    logic        ras_write, ras_waitrequest;
    logic [3:0]  ras_byteenable;
    logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
    logic        cpu_read, cpu_write, cpu_waitrequest, cpu_readdatavalid;
    logic [3:0]  cpu_byteenable;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [3:0]  m_byteenable;
    logic        err_orphan;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_acc[$];
    exp_t exp_rsp[$];

    always #5 clk = ~clk;

    fb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PEND(8)) dut (
        .clk(clk), .reset(reset),
        .scan_address(scan_address), .scan_read(scan_read), .scan_urgent(scan_urgent),
        .scan_waitrequest(scan_waitrequest), .scan_readdata(scan_readdata),
        .scan_readdatavalid(scan_readdatavalid),
        .ras_address(ras_address), .ras_write(ras_write), .ras_writedata(ras_writedata),
        .ras_byteenable(ras_byteenable), .ras_waitrequest(ras_waitrequest),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .err_orphan(err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        scan_read = 1'b0; scan_urgent = 1'b0; scan_address = 32'h0;
        ras_write = 1'b0; ras_address = 32'h0; ras_writedata = 32'h0; ras_byteenable = 4'h0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 32'h0;
        cpu_writedata = 32'h0; cpu_byteenable = 4'h0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'h0;
    endtask

    task automatic push_acc(input logic [1:0] id, input logic [31:0] a);
        exp_t e;
        e.id = id; e.val = a;
        exp_acc.push_back(e);
    endtask

    task automatic push_rsp(input logic [1:0] id, input logic [31:0] d);
        exp_t e;
        e.id = id; e.val = d;
        exp_rsp.push_back(e);
    endtask

    // One memory response cycle carrying d, expected to land at requester id.
    task automatic rsp(input logic [1:0] id, input logic [31:0] d);
        push_rsp(id, d);
        m_readdatavalid = 1'b1;
        m_readdata      = d;
        tick();
        m_readdatavalid = 1'b0;
        m_readdata      = 32'h0;
    endtask

    // Acceptance monitor: exactly one winner, in the queued order and address.
    always @(negedge clk) begin : mon_acc
        int         n;
        logic [1:0] oid;
        exp_t       e;
        if (!reset) begin
            n = 0;
            oid = 2'd0;
            if (!scan_waitrequest) begin n++; oid = REQ_SCAN; end
            if (!ras_waitrequest)  begin n++; oid = REQ_RAS;  end
            if (!cpu_waitrequest)  begin n++; oid = REQ_CPU;  end
            if (n != 0) begin
                chk("acc_one_winner", n, 1);
                chk("acc_expected", exp_acc.size() != 0, 1);
                if (exp_acc.size() != 0) begin
                    e = exp_acc.pop_front();
                    chk("acc_id", oid, e.id);
                    chk("acc_addr", m_address, e.val);
                end
            end
        end
    end

    // Response monitor: data goes to the queued requester with queued data.
    always @(negedge clk) begin : mon_rsp
        exp_t e;
        if (!reset && (scan_readdatavalid || cpu_readdatavalid)) begin
            chk("rsp_one_valid", {1'b0, scan_readdatavalid} + {1'b0, cpu_readdatavalid}, 1);
            chk("rsp_expected", exp_rsp.size() != 0, 1);
            if (exp_rsp.size() != 0) begin
                e = exp_rsp.pop_front();
                if (scan_readdatavalid) begin
                    chk("rsp_id", REQ_SCAN, e.id);
                    chk("rsp_data", scan_readdata, e.val);
                end else begin
                    chk("rsp_id", REQ_CPU, e.id);
                    chk("rsp_data", cpu_readdata, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, observed %0d expected 0 pending", exp_acc.size());
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [1:0]  rr_ord [3];
        logic [31:0] rr_adr [3];
        rr_ord[0] = REQ_SCAN; rr_ord[1] = REQ_RAS; rr_ord[2] = REQ_CPU;
        rr_adr[0] = SCAN_A;   rr_adr[1] = RAS_A;   rr_adr[2] = CPU_A;

        idle();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_writedata", m_writedata, 0);
        chk("rst_m_byteenable", m_byteenable, 0);
        chk("rst_wait", {scan_waitrequest, ras_waitrequest, cpu_waitrequest}, 3'b111);
        chk("rst_rdv", {scan_readdatavalid, cpu_readdatavalid}, 2'b00);
        chk("rst_rdata", {scan_readdata, cpu_readdata}, 64'h0);
        chk("rst_err", err_orphan, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin with all three requesting continuously.
        scan_read = 1'b1; scan_address = SCAN_A;
        ras_write = 1'b1; ras_address = RAS_A; ras_writedata = 32'hA5A5_0001; ras_byteenable = 4'hF;
        cpu_write = 1'b1; cpu_address = CPU_A; cpu_writedata = 32'h5A5A_0001; cpu_byteenable = 4'h3;
        for (int i = 0; i < 6; i++) begin
            push_acc(rr_ord[i % 3], rr_adr[i % 3]);
            if (i == 1) begin
                @(negedge clk);
                chk("rr_ras_wdata", m_writedata, 32'hA5A5_0001);
                chk("rr_ras_be", m_byteenable, 4'hF);
            end
            tick();
        end
        idle();
        rsp(REQ_SCAN, 32'h1111_0001);
        rsp(REQ_SCAN, 32'h1111_0002);
        tick();

        // Urgent scan-out overrides round-robin when rr_ptr points at cpu.
        ras_write = 1'b1; ras_address = RAS_A + 32'h4; ras_byteenable = 4'hF;
        cpu_write = 1'b1; cpu_address = CPU_A + 32'h4; cpu_byteenable = 4'hF;
        push_acc(REQ_RAS, RAS_A + 32'h4);
        tick();
        scan_read = 1'b1; scan_address = SCAN_A + 32'h4; scan_urgent = 1'b1;
        push_acc(REQ_SCAN, SCAN_A + 32'h4);
        tick();
        scan_read = 1'b0; scan_urgent = 1'b0;
        push_acc(REQ_RAS, RAS_A + 32'h4);
        tick();
        push_acc(REQ_CPU, CPU_A + 32'h4);
        tick();
        idle();
        rsp(REQ_SCAN, 32'h2222_0001);
        tick();

        // Lock: stalled cpu write holds the port despite urgent scan-out.
        cpu_write = 1'b1; cpu_address = CPU_A + 32'h40; cpu_writedata = 32'hC0C0_0040;
        cpu_byteenable = 4'hF; m_waitrequest = 1'b1;
        @(negedge clk);
        chk("lock_c1_addr", m_address, CPU_A + 32'h40);
        chk("lock_c1_cpu_wait", cpu_waitrequest, 1);
        tick();
        scan_read = 1'b1; scan_address = SCAN_A + 32'h80; scan_urgent = 1'b1;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            chk("lock_hold_addr", m_address, CPU_A + 32'h40);
            chk("lock_hold_write", {m_write, m_read}, 2'b10);
            chk("lock_hold_cpu_wait", cpu_waitrequest, 1);
            chk("lock_hold_scan_wait", scan_waitrequest, 1);
            tick();
        end
        m_waitrequest = 1'b0;
        push_acc(REQ_CPU, CPU_A + 32'h40);
        tick();
        cpu_write = 1'b0;
        push_acc(REQ_SCAN, SCAN_A + 32'h80);
        tick();
        idle();
        rsp(REQ_SCAN, 32'h3333_0001);
        tick();

        // Outstanding-read limit: 8 reads fill the tag FIFO.
        scan_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            scan_address = SCAN_A + 32'h100 + 32'(i * 4);
            push_acc(REQ_SCAN, scan_address);
            tick();
        end
        scan_address = SCAN_A + 32'h200;
        ras_write = 1'b1; ras_address = RAS_A + 32'h100; ras_byteenable = 4'hF;
        push_acc(REQ_RAS, RAS_A + 32'h100);
        @(negedge clk);
        chk("full_scan_stall", scan_waitrequest, 1);
        tick();
        ras_write = 1'b0;
        push_rsp(REQ_SCAN, 32'h4444_0000);
        m_readdatavalid = 1'b1; m_readdata = 32'h4444_0000;
        @(negedge clk);
        chk("full_pop_no_grant", {scan_waitrequest, m_read}, 2'b10);
        tick();
        push_acc(REQ_SCAN, SCAN_A + 32'h200);
        push_rsp(REQ_SCAN, 32'h4444_0001);
        m_readdata = 32'h4444_0001;
        tick();
        m_readdatavalid = 1'b0;
        scan_read = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            rsp(REQ_SCAN, 32'h4444_0000 + 32'(i));
        end
        tick();

        // Interleaved readers: responses follow issue order, one cycle late.
        cpu_read = 1'b1; cpu_address = CPU_A + 32'h10;
        push_acc(REQ_CPU, CPU_A + 32'h10);
        tick();
        cpu_read = 1'b0; scan_read = 1'b1; scan_address = SCAN_A + 32'h10;
        push_acc(REQ_SCAN, SCAN_A + 32'h10);
        tick();
        scan_read = 1'b0; cpu_read = 1'b1; cpu_address = CPU_A + 32'h14;
        push_acc(REQ_CPU, CPU_A + 32'h14);
        tick();
        cpu_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hD000_0000;
        push_rsp(REQ_CPU, 32'hD000_0000);
        @(negedge clk);
        chk("ord_m0_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b00);
        tick();
        m_readdata = 32'hD000_0001;
        push_rsp(REQ_SCAN, 32'hD000_0001);
        @(negedge clk);
        chk("ord_m1_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b01);
        tick();
        m_readdata = 32'hD000_0002;
        push_rsp(REQ_CPU, 32'hD000_0002);
        @(negedge clk);
        chk("ord_m2_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b10);
        tick();
        m_readdatavalid = 1'b0; m_readdata = 32'h0;
        @(negedge clk);
        chk("ord_m3_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b01);
        tick();
        @(negedge clk);
        chk("ord_m4_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b00);
        tick();

        // cpu read and write together is issued as a write (no tag pushed).
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = CPU_A + 32'h200; cpu_byteenable = 4'hF;
        push_acc(REQ_CPU, CPU_A + 32'h200);
        @(negedge clk);
        chk("rw_as_write", {m_write, m_read}, 2'b10);
        tick();
        idle();

        // Orphan response: no tag outstanding.
        m_readdatavalid = 1'b1; m_readdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("orph_before", err_orphan, 0);
        tick();
        m_readdatavalid = 1'b0; m_readdata = 32'h0;
        @(negedge clk);
        chk("orph_set", err_orphan, 1);
        chk("orph_no_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b00);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("orph_sticky", err_orphan, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("orph_reset_clear", err_orphan, 0);
        tick();
        reset = 1'b0;

        // Reset with a read in flight: the late response becomes an orphan.
        scan_read = 1'b1; scan_address = SCAN_A + 32'h300;
        push_acc(REQ_SCAN, SCAN_A + 32'h300);
        tick();
        scan_read = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_err_clear", err_orphan, 0);
        tick();
        m_readdatavalid = 1'b1; m_readdata = 32'hBAD0_0001;
        tick();
        m_readdatavalid = 1'b0; m_readdata = 32'h0;
        @(negedge clk);
        chk("midrst_orphan", err_orphan, 1);
        chk("midrst_no_valid", {scan_readdatavalid, cpu_readdatavalid}, 2'b00);
        tick();

        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
